// File: rtl/and_stim_gen.sv
// rtl/and_stim_gen.sv - timed 12-vector i1/i2 stimulus source for the AND sequence checker
module and_stim_gen #(
  parameter int DWELL = 500,
  parameter int CNT_W = 16,
  parameter int LOOP  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       stop,
  output logic       i1,
  output logic       i2,
  output logic       y_exp,
  output logic [3:0] step_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, RUN} state_t;

  // A dwell of 0 behaves exactly like a dwell of 1.
  localparam int              DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_EFF - 1);
  localparam logic [3:0]      LAST_STEP = 4'd11;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       step_nxt;
  logic [1:0]       vec_nxt;

  function automatic logic [1:0] vec_of(input logic [3:0] s);
    logic [1:0] v;
    case (s)
      4'd0:    v = 2'b00;
      4'd1:    v = 2'b10;
      4'd2:    v = 2'b11;
      4'd3:    v = 2'b01;
      4'd4:    v = 2'b00;
      4'd5:    v = 2'b10;
      4'd6:    v = 2'b11;
      4'd7:    v = 2'b01;
      4'd8:    v = 2'b00;
      4'd9:    v = 2'b01;
      4'd10:   v = 2'b11;
      4'd11:   v = 2'b01;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  assign step_nxt = step_idx + 4'd1;
  assign vec_nxt  = vec_of(step_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      step_idx <= 4'd0;
      i1       <= 1'b0;
      i2       <= 1'b0;
      y_exp    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            step_idx <= 4'd0;
            i1       <= 1'b0;
            i2       <= 1'b0;
            y_exp    <= 1'b0;
            cnt      <= RELOAD;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort wins over any pending advance; no done pulse.
            state    <= IDLE;
            busy     <= 1'b0;
            step_idx <= 4'd0;
            i1       <= 1'b0;
            i2       <= 1'b0;
            y_exp    <= 1'b0;
            cnt      <= '0;
          end else if (!hold) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (step_idx == LAST_STEP) begin
              done     <= 1'b1;
              step_idx <= 4'd0;
              i1       <= 1'b0;
              i2       <= 1'b0;
              y_exp    <= 1'b0;
              if (LOOP != 0) begin
                cnt <= RELOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
              end
            end else begin
              // i1, i2 and y_exp all change on the same edge so the checker never sees a mixed vector.
              step_idx <= step_nxt;
              i1       <= vec_nxt[1];
              i2       <= vec_nxt[0];
              y_exp    <= vec_nxt[1] & vec_nxt[0];
              cnt      <= RELOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_stim_gen.sv
// tb/tb_and_stim_gen.sv - randomized scoreboard bench for and_stim_gen (three configurations)
module tb_and_stim_gen;

  logic clk = 1'b0;
  logic reset, start, hold, stop;

  logic       i1_a, i2_a, y_a, busy_a, done_a;
  logic [3:0] step_a;
  logic       i1_b, i2_b, y_b, busy_b, done_b;
  logic [3:0] step_b;
  logic       i1_c, i2_c, y_c, busy_c, done_c;
  logic [3:0] step_c;

  always #5 clk = ~clk;

  and_stim_gen #(.DWELL(4), .CNT_W(8), .LOOP(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .stop(stop),
    .i1(i1_a), .i2(i2_a), .y_exp(y_a), .step_idx(step_a), .busy(busy_a), .done(done_a));
  and_stim_gen #(.DWELL(2), .CNT_W(4), .LOOP(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .stop(stop),
    .i1(i1_b), .i2(i2_b), .y_exp(y_b), .step_idx(step_b), .busy(busy_b), .done(done_b));
  and_stim_gen #(.DWELL(0), .CNT_W(4), .LOOP(0)) dut_c (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .stop(stop),
    .i1(i1_c), .i2(i2_c), .y_exp(y_c), .step_idx(step_c), .busy(busy_c), .done(done_c));

  int checks = 0;
  int errors = 0;

  // Reference model: a run flag, the current step, and cycles elapsed inside that step.
  int dw_cfg [3]   = '{4, 2, 1};
  int loop_cfg [3] = '{0, 1, 0};
  int tab_i1 [12]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0};
  int tab_i2 [12]  = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
  int m_run [3]    = '{0, 0, 0};
  int m_step [3]   = '{0, 0, 0};
  int m_age [3]    = '{0, 0, 0};
  int m_done [3]   = '{0, 0, 0};

  logic [26:0] exp_q[$];

  function automatic logic [8:0] model_out(input int d);
    logic a, b;
    a = (m_run[d] != 0) ? (tab_i1[m_step[d]] != 0) : 1'b0;
    b = (m_run[d] != 0) ? (tab_i2[m_step[d]] != 0) : 1'b0;
    return {a, b, a & b, 4'(m_step[d]), (m_run[d] != 0), (m_done[d] != 0)};
  endfunction

  task automatic model_edge();
    logic [26:0] e;
    for (int d = 0; d < 3; d++) begin
      m_done[d] = 0;
      if (reset) begin
        m_run[d] = 0; m_step[d] = 0; m_age[d] = 0;
      end else if (m_run[d] == 0) begin
        if (start && !stop) begin
          m_run[d] = 1; m_step[d] = 0; m_age[d] = 0;
        end
      end else if (stop) begin
        m_run[d] = 0; m_step[d] = 0; m_age[d] = 0;
      end else if (!hold) begin
        m_age[d] = m_age[d] + 1;
        if (m_age[d] >= dw_cfg[d]) begin
          m_age[d] = 0;
          if (m_step[d] == 11) begin
            m_done[d] = 1;
            m_step[d] = 0;
            if (loop_cfg[d] == 0) m_run[d] = 0;
          end else begin
            m_step[d] = m_step[d] + 1;
          end
        end
      end
    end
    e = {model_out(2), model_out(1), model_out(0)};
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Monitor: every cycle each DUT presents its output word; compare against the queued expectation.
  initial forever begin
    logic [26:0] e;
    logic [8:0]  act [3];
    @(negedge clk);
    act[0] = {i1_a, i2_a, y_a, step_a, busy_a, done_a};
    act[1] = {i1_b, i2_b, y_b, step_b, busy_b, done_b};
    act[2] = {i1_c, i2_c, y_c, step_c, busy_c, done_c};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== e[d*9 +: 9]) begin
          errors++;
          $display("FAIL scoreboard dut%0d t=%0t actual i1i2y/step/busy/done=%b required %b",
                   d, $time, act[d], e[d*9 +: 9]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Pulse start, optionally hold for hold_len cycles from cycle hold_at, and return done latency.
  task automatic run_pass(input int hold_at, input int hold_len, output int lat);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    lat = -1;
    while (n < 300) begin
      if (n == hold_at) hold = 1'b1;
      if (n == hold_at + hold_len) hold = 1'b0;
      if (done_a === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    hold = 1'b0;
  endtask

  int lat;

  initial begin
    reset = 1'b1; start = 1'b1; hold = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_step", int'(step_a), 0);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'(busy_a), 0);

    run_pass(0, 0, lat);
    chk("pass_latency", lat, 49);
    @(negedge clk);
    chk("idle_after_done", int'(busy_a), 0);
    chk("done_one_cycle", int'(done_a), 0);

    run_pass(22, 3, lat);
    chk("hold_latency", lat, 52);

    // Stop in step 7 on the cycle its counter reaches 0.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (31) @(negedge clk);
    chk("pre_stop_step", int'(step_a), 7);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_busy", int'(busy_a), 0);
    chk("stop_step", int'(step_a), 0);
    chk("stop_no_done", int'(done_a), 0);
    run_pass(0, 0, lat);
    chk("pass_after_stop", lat, 49);

    // Reset during step 3 with start held.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_reset_step", int'(step_a), 3);
    reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    chk("midrun_reset_busy", int'(busy_a), 0);
    chk("midrun_reset_i2", int'(i2_a), 0);

    // Randomized phase; the scoreboard checks every cycle of all three configurations.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; hold = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
